// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator (pixel enable, pixel coordinates, VGA syncs, frame strobe).
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output and its register.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        p_tick,
    output logic [9:0]  p_x,
    output logic [9:0]  p_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] H_VIS_LAST = 10'(H_DISPLAY - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_DISPLAY - 1);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    // A one-cycle divider still needs a 1-bit counter to keep the declaration legal.
    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             hsync_next;
    logic             vsync_next;
    logic             frame_tick_next;

    assign div_last = (div_cnt == DIV_LAST);

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        x_next = p_x;
        y_next = p_y;
        if (p_tick) begin
            if (p_x == H_LAST) begin
                x_next = '0;
                y_next = (p_y == V_LAST) ? '0 : p_y + 10'd1;
            end else begin
                x_next = p_x + 10'd1;
            end
        end
    end

    // Syncs and the frame strobe are built from the coming coordinates so the
    // registered versions line up with the p_x/p_y they describe.
    always_comb begin
        hsync_next      = !((x_next >= HS_START) && (x_next < HS_END));
        vsync_next      = !((y_next >= VS_START) && (y_next < VS_END));
        frame_tick_next = div_last && (x_next == H_VIS_LAST) && (y_next == V_VIS_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            p_tick     <= 1'b0;
            p_x        <= '0;
            p_y        <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_last ? '0 : div_cnt + DIV_W'(1);
            p_tick     <= div_last;
            p_x        <= x_next;
            p_y        <= y_next;
            hsync      <= hsync_next;
            vsync      <= vsync_next;
            frame_tick <= frame_tick_next;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Advances on the same edge that raises frame_tick; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_tick_next) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    assign video_on = (p_x < H_VIS) && (p_y < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen on a full-size 640x480 instance,
// a tiny-raster instance for frame-level behaviour, and a TICK_DIV=1 instance.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Instance A: default 640x480 timing, TICK_DIV=2
    logic       rst_a = 1'b1;
    logic       p_tick_a, video_on_a, hsync_a, vsync_a, frame_tick_a;
    logic [9:0] p_x_a, p_y_a;
    // Instance B: 8x6 visible, H total 15 (hsync x 10..12), V total 13 (vsync y 8..9), TICK_DIV=1
    logic       rst_b = 1'b1;
    logic       p_tick_b, video_on_b, hsync_b, vsync_b, frame_tick_b;
    logic [9:0] p_x_b, p_y_b;
    // Instance C: default 640x480 timing, TICK_DIV=1
    logic       rst_c = 1'b1;
    logic       p_tick_c, video_on_c, hsync_c, vsync_c, frame_tick_c;
    logic [9:0] p_x_c, p_y_c;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_a, frame_cnt_b, frame_cnt_c;
`endif

    vga_sync_gen dut_a (
        .clk(clk), .reset(rst_a), .p_tick(p_tick_a), .p_x(p_x_a), .p_y(p_y_a),
        .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a), .frame_tick(frame_tick_a)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(frame_cnt_a)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .TICK_DIV(1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .p_tick(p_tick_b), .p_x(p_x_b), .p_y(p_y_b),
        .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b), .frame_tick(frame_tick_b)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(frame_cnt_b)
`endif
    );

    vga_sync_gen #(.TICK_DIV(1)) dut_c (
        .clk(clk), .reset(rst_c), .p_tick(p_tick_c), .p_x(p_x_c), .p_y(p_y_c),
        .video_on(video_on_c), .hsync(hsync_c), .vsync(vsync_c), .frame_tick(frame_tick_c)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(frame_cnt_c)
`endif
    );

    initial begin
        // ---------------- Instance A: reset state ----------------
        repeat (3) @(negedge clk);
        check("a_rst_p_x", p_x_a, 0);
        check("a_rst_p_y", p_y_a, 0);
        check("a_rst_p_tick", p_tick_a, 0);
        check("a_rst_hsync", hsync_a, 1);
        check("a_rst_vsync", vsync_a, 1);
        check("a_rst_frame_tick", frame_tick_a, 0);
        check("a_rst_video_on", video_on_a, 1);
`ifdef VGA_FRAME_CNT_EN
        check("a_rst_frame_cnt", frame_cnt_a, 0);
`endif
        rst_a = 1'b0;

        // ---------------- Instance A: divider, line wrap, hsync ----------------
        begin
            int first_tick = -1, last_tick = -1, gap_err = 0, n_ticks = 0;
            int max_x = 0, wraps = 0, prev_x = 0;
            int fall1 = -1, fall2 = -1, fall_x = -1, rise_x = -1, low_ticks = 0;
            int vid_err = 0, ft_seen = 0, vs_low = 0;
            logic prev_h = 1'b1;
            for (int i = 1; i <= 4000; i++) begin
                @(negedge clk);
                if (p_tick_a) begin
                    if (first_tick < 0) first_tick = i;
                    else if (i - last_tick != 2) gap_err++;
                    last_tick = i;
                    n_ticks++;
                end
                if (int'(p_x_a) > max_x) max_x = int'(p_x_a);
                if (prev_x == 799 && p_x_a == 10'd0) wraps++;
                if (prev_h && !hsync_a) begin
                    if (fall1 < 0) begin
                        fall1 = i;
                        fall_x = int'(p_x_a);
                    end else if (fall2 < 0) begin
                        fall2 = i;
                    end
                end
                if (!prev_h && hsync_a && rise_x < 0) rise_x = int'(p_x_a);
                if (fall1 >= 0 && rise_x < 0 && !hsync_a && p_tick_a) low_ticks++;
                if (p_x_a == 10'd640 && video_on_a) vid_err++;
                if (p_x_a == 10'd639 && !video_on_a) vid_err++;
                if (frame_tick_a) ft_seen++;
                if (!vsync_a) vs_low++;
                prev_h = hsync_a;
                prev_x = int'(p_x_a);
            end
            check("a_first_tick_clks", first_tick, 2);
            check("a_tick_gap_errors", gap_err, 0);
            check("a_tick_count", n_ticks, 2000);
            check("a_max_p_x", max_x, 799);
            check("a_line_wraps", wraps, 2);
            check("a_p_y_after_2_lines", p_y_a, 2);
            check("a_hsync_fall_x", fall_x, 656);
            check("a_hsync_rise_x", rise_x, 752);
            check("a_hsync_low_ticks", low_ticks, 96);
            check("a_hsync_fall_period", fall2 - fall1, 1600);
            check("a_video_on_edge_errors", vid_err, 0);
            check("a_frame_tick_in_top_lines", ft_seen, 0);
            check("a_vsync_low_in_top_lines", vs_low, 0);
        end

        // ---------------- Instance A: reset during hsync pulse ----------------
        begin
            int budget = 0;
            while (p_x_a != 10'd700 && budget < 2000) begin
                @(negedge clk);
                budget++;
            end
            check("a_reach_x700", p_x_a, 700);
            check("a_hsync_low_at_700", hsync_a, 0);
            rst_a = 1'b1;
            @(negedge clk);
            check("a_mid_rst_p_x", p_x_a, 0);
            check("a_mid_rst_p_y", p_y_a, 0);
            check("a_mid_rst_p_tick", p_tick_a, 0);
            check("a_mid_rst_hsync", hsync_a, 1);
            check("a_mid_rst_vsync", vsync_a, 1);
            rst_a = 1'b0;
            @(negedge clk);
            check("a_resume_tick_clk1", p_tick_a, 0);
            @(negedge clk);
            check("a_resume_tick_clk2", p_tick_a, 1);
            check("a_resume_p_x", p_x_a, 0);
        end

        // ---------------- Instance B: full frames ----------------
        rst_b = 1'b0;
        begin
            int first_ft = -1, second_ft = -1, ft_high = 0, ft_bad_pos = 0;
            int vs_fall_y = -1, vs_rise_y = -1, vs_fall_i = -1, vs_low_ticks = 0;
            int y_wraps = 0, max_y = 0, prev_y = 0, vid_err = 0, hs_err = 0, tick_low = 0;
            logic prev_v = 1'b1;
            logic [31:0] cnt_ft1 = 0, cnt_ft2 = 0;
            for (int i = 1; i <= 410; i++) begin
                @(negedge clk);
                if (!p_tick_b) tick_low++;
                if (frame_tick_b) begin
                    ft_high++;
                    if (!(p_x_b == 10'd7 && p_y_b == 10'd5 && p_tick_b)) ft_bad_pos++;
                    if (first_ft < 0) begin
                        first_ft = i;
`ifdef VGA_FRAME_CNT_EN
                        cnt_ft1 = 32'(frame_cnt_b);
`endif
                    end else if (second_ft < 0) begin
                        second_ft = i;
`ifdef VGA_FRAME_CNT_EN
                        cnt_ft2 = 32'(frame_cnt_b);
`endif
                    end
                end
                if (prev_v && !vsync_b && vs_fall_y < 0) begin
                    vs_fall_y = int'(p_y_b);
                    vs_fall_i = i;
                end
                if (!prev_v && vsync_b && vs_rise_y < 0) vs_rise_y = int'(p_y_b);
                if (vs_fall_y >= 0 && vs_rise_y < 0 && !vsync_b && p_tick_b) vs_low_ticks++;
                if (prev_y == 12 && p_y_b == 10'd0) y_wraps++;
                if (int'(p_y_b) > max_y) max_y = int'(p_y_b);
                if (video_on_b !== (p_x_b < 10'd8 && p_y_b < 10'd6)) vid_err++;
                if (hsync_b !== !(p_x_b >= 10'd10 && p_x_b <= 10'd12)) hs_err++;
                prev_v = vsync_b;
                prev_y = int'(p_y_b);
            end
            check("b_p_tick_never_low", tick_low, 0);
            check("b_first_frame_tick_clk", first_ft, 83);
            check("b_frame_tick_period", second_ft - first_ft, 195);
            check("b_frame_tick_high_clks", ft_high, 2);
            check("b_frame_tick_bad_position", ft_bad_pos, 0);
            check("b_vsync_fall_y", vs_fall_y, 8);
            check("b_vsync_fall_clk", vs_fall_i, 121);
            check("b_vsync_rise_y", vs_rise_y, 10);
            check("b_vsync_low_ticks", vs_low_ticks, 30);
            check("b_frame_wraps", y_wraps, 2);
            check("b_max_p_y", max_y, 12);
            check("b_video_on_errors", vid_err, 0);
            check("b_hsync_errors", hs_err, 0);
`ifdef VGA_FRAME_CNT_EN
            check("b_frame_cnt_after_ft1", cnt_ft1, 1);
            check("b_frame_cnt_after_ft2", cnt_ft2, 2);
`endif
        end

        // ---------------- Instance B: reset during both sync pulses ----------------
        begin
            int budget = 0;
            while (!(p_x_b == 10'd11 && p_y_b == 10'd8) && budget < 300) begin
                @(negedge clk);
                budget++;
            end
            check("b_reach_x11_y8", {p_y_b, p_x_b}, {10'd8, 10'd11});
            check("b_hsync_low_before_rst", hsync_b, 0);
            check("b_vsync_low_before_rst", vsync_b, 0);
            rst_b = 1'b1;
            @(negedge clk);
            check("b_mid_rst_xy", {p_y_b, p_x_b}, 0);
            check("b_mid_rst_syncs", {hsync_b, vsync_b}, 2'b11);
            check("b_mid_rst_p_tick", p_tick_b, 0);
`ifdef VGA_FRAME_CNT_EN
            check("b_mid_rst_frame_cnt", frame_cnt_b, 0);
`endif
            rst_b = 1'b0;
            @(negedge clk);
            check("b_resume_tick", p_tick_b, 1);
            check("b_resume_p_x0", p_x_b, 0);
            @(negedge clk);
            check("b_resume_p_x1", p_x_b, 1);
        end

        // ---------------- Instance C: TICK_DIV=1 at full size ----------------
        rst_c = 1'b0;
        begin
            int tick_low = 0, fall1 = -1, fall2 = -1, fall_x = -1;
            logic prev_h = 1'b1;
            for (int i = 1; i <= 1700; i++) begin
                @(negedge clk);
                if (!p_tick_c) tick_low++;
                if (prev_h && !hsync_c) begin
                    if (fall1 < 0) begin
                        fall1 = i;
                        fall_x = int'(p_x_c);
                    end else if (fall2 < 0) begin
                        fall2 = i;
                    end
                end
                prev_h = hsync_c;
            end
            check("c_p_tick_never_low", tick_low, 0);
            check("c_hsync_fall_x", fall_x, 656);
            check("c_hsync_fall_clk", fall1, 657);
            check("c_line_period_clks", fall2 - fall1, 800);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
